// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus between the execute/memory-stage writers and the register-file arbiter.
// Latency: none (wires only); req_ready is produced combinationally by the arbiter.
// Backpressure: a requester holds req_valid, req_reg and req_data until its req_ready bit is seen.
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
);
    logic                      wb_hold;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_reg;
    logic [NUM_REQ*DATA_W-1:0] req_data;

    // Requester side drives the writes and the hold.
    modport master (
        output wb_hold,
        output req_valid,
        output req_reg,
        output req_data,
        input  req_ready
    );

    // Arbiter side returns the one-hot grant.
    modport slave (
        input  wb_hold,
        input  req_valid,
        input  req_reg,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file's single write port, with optional read bypass (REGWB_BYPASS_EN).
// Latency: grant in cycle N, register-file write presented in cycle N+1; one write per cycle.
// Backpressure: wb_hold or reset blocks every grant; losers keep req_valid high until granted.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic               clock,
    input  logic               ctrl_reset_n,
    regfile_wb_arbiter_if.slave wb,
    output logic               ctrl_writeEnable,
    output logic [ADDR_W-1:0]  ctrl_writeReg,
    output logic [DATA_W-1:0]  data_writeReg,
    input  logic [ADDR_W-1:0]  ctrl_readRegA,
    input  logic [ADDR_W-1:0]  ctrl_readRegB,
    output logic               byp_hitA,
    output logic               byp_hitB,
    output logic [DATA_W-1:0]  byp_dataA,
    output logic [DATA_W-1:0]  byp_dataB
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W-1:0]  next_ptr;
    logic [PTR_W:0]    cand;
    logic              grant_found;
    logic              xfer;
    logic [ADDR_W-1:0] sel_reg;
    logic [DATA_W-1:0] sel_data;

    logic              we_q, we_d;
    logic [ADDR_W-1:0] wreg_q, wreg_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;

    // Search valid requesters starting at rr_ptr, wrapping modulo NUM_REQ; first hit wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
                cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!grant_found && wb.req_valid[cand[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end
    end

    // Grant is blocked by hold and while reset is asserted, so nothing completes during reset.
    assign xfer     = grant_found & ~wb.wb_hold & ctrl_reset_n;
    assign next_ptr = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // One-hot ready for the winner only; a requester without valid never sees ready.
    always_comb begin
        wb.req_ready = '0;
        if (xfer) begin
            wb.req_ready[grant_idx] = 1'b1;
        end
    end

    // Select the winner's destination index and data.
    always_comb begin
        sel_reg  = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                sel_reg  = wb.req_reg[i*ADDR_W +: ADDR_W];
                sel_data = wb.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next state: a transfer advances the pointer; writes to r0 complete the handshake but are dropped.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        we_d     = 1'b0;
        wreg_d   = wreg_q;
        wdat_d   = wdat_q;
        if (xfer) begin
            rr_ptr_d = next_ptr;
            if (sel_reg != '0) begin
                we_d   = 1'b1;
                wreg_d = sel_reg;
                wdat_d = sel_data;
            end
        end
    end

    // Pointer and register-file write port state; reset discards any in-flight write.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            rr_ptr_q <= '0;
            we_q     <= 1'b0;
            wreg_q   <= '0;
            wdat_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            we_q     <= we_d;
            wreg_q   <= wreg_d;
            wdat_q   <= wdat_d;
        end
    end

    assign ctrl_writeEnable = we_q;
    assign ctrl_writeReg    = wreg_q;
    assign data_writeReg    = wdat_q;

`ifdef REGWB_BYPASS_EN
    // Forward the write being presented this cycle, before the register file has stored it.
    always_comb begin
        byp_hitA  = we_q & (wreg_q == ctrl_readRegA) & (ctrl_readRegA != '0);
        byp_hitB  = we_q & (wreg_q == ctrl_readRegB) & (ctrl_readRegB != '0);
        byp_dataA = byp_hitA ? wdat_q : '0;
        byp_dataB = byp_hitB ? wdat_q : '0;
    end
`else
    // Bypass disabled: ports stay present but are tied off; read indices are deliberately ignored.
    logic unused_rd_idx;
    assign unused_rd_idx = ^{ctrl_readRegA, ctrl_readRegB};
    assign byp_hitA  = 1'b0;
    assign byp_hitB  = 1'b0;
    assign byp_dataA = '0;
    assign byp_dataB = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single write, round-robin, r0 drop, hold, mid-reset, bypass.
// Latency: checks registered outputs one cycle after the grant they follow.
// Backpressure: exercises wb_hold and reset blocking of req_ready.
module tb_regfile_wb_arbiter;
    localparam int NUM_REQ = 3;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;

    logic              clock = 1'b0;
    logic              rst_n = 1'b0;
    logic              we;
    logic [ADDR_W-1:0] wreg;
    logic [DATA_W-1:0] wdat;
    logic [ADDR_W-1:0] rd_a = '0;
    logic [ADDR_W-1:0] rd_b = '0;
    logic              hit_a, hit_b;
    logic [DATA_W-1:0] bdat_a, bdat_b;

    int errors = 0;
    int checks = 0;

    regfile_wb_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) rf_if ();

    regfile_wb_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clock            (clock),
        .ctrl_reset_n     (rst_n),
        .wb               (rf_if.slave),
        .ctrl_writeEnable (we),
        .ctrl_writeReg    (wreg),
        .data_writeReg    (wdat),
        .ctrl_readRegA    (rd_a),
        .ctrl_readRegB    (rd_b),
        .byp_hitA         (hit_a),
        .byp_hitB         (hit_b),
        .byp_dataA        (bdat_a),
        .byp_dataB        (bdat_b)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
        rf_if.req_reg[i*ADDR_W +: ADDR_W]  = r;
        rf_if.req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rf_if.req_valid = '0;
        rf_if.wb_hold   = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rf_if.wb_hold   = 1'b0;
        rf_if.req_valid = 3'b111;
        set_req(0, 5'd1, 32'h1111_0000);
        set_req(1, 5'd2, 32'h2222_0000);
        set_req(2, 5'd3, 32'h3333_0000);
        tick();
        tick();
        @(negedge clock);
        checks++; if (rf_if.req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got=%b exp=000", rf_if.req_ready); end
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", we); end
        checks++; if (wreg !== 5'd0) begin errors++; $display("FAIL reset_wreg got=%0d exp=0", wreg); end
        checks++; if (wdat !== 32'd0) begin errors++; $display("FAIL reset_wdat got=%h exp=0", wdat); end
        checks++; if (hit_a !== 1'b0 || hit_b !== 1'b0) begin errors++; $display("FAIL reset_hits got=%b%b exp=00", hit_a, hit_b); end
        rf_if.req_valid = '0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        rf_if.req_valid = 3'b010;
        set_req(1, 5'd7, 32'hDEAD_BEEF);
        @(negedge clock);
        checks++; if (rf_if.req_ready !== 3'b010) begin errors++; $display("FAIL single_ready got=%b exp=010", rf_if.req_ready); end
        tick();
        rf_if.req_valid = '0;
        @(negedge clock);
        checks++; if (we !== 1'b1) begin errors++; $display("FAIL single_we got=%b exp=1", we); end
        checks++; if (wreg !== 5'd7) begin errors++; $display("FAIL single_wreg got=%0d exp=7", wreg); end
        checks++; if (wdat !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_wdat got=%h exp=deadbeef", wdat); end
        tick();
        @(negedge clock);
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL single_we_after got=%b exp=0", we); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [NUM_REQ-1:0] exp_rdy;
        logic [ADDR_W-1:0]  exp_reg;
        logic [DATA_W-1:0]  exp_dat;
        do_reset();
        set_req(0, 5'd1, 32'hA000_0000);
        set_req(1, 5'd2, 32'hA000_0001);
        set_req(2, 5'd3, 32'hA000_0002);
        rf_if.req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            exp_rdy = NUM_REQ'(1 << (c % 3));
            checks++; if (rf_if.req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready[%0d] got=%b exp=%b", c, rf_if.req_ready, exp_rdy); end
            if (c > 0) begin
                exp_reg = ADDR_W'(((c - 1) % 3) + 1);
                exp_dat = 32'hA000_0000 + DATA_W'((c - 1) % 3);
                checks++; if (we !== 1'b1 || wreg !== exp_reg || wdat !== exp_dat) begin
                    errors++; $display("FAIL rr_write[%0d] got=%b/%0d/%h exp=1/%0d/%h", c, we, wreg, wdat, exp_reg, exp_dat);
                end
            end
            tick();
        end
        @(negedge clock);
        checks++; if (we !== 1'b1 || wreg !== 5'd3 || wdat !== 32'hA000_0002) begin
            errors++; $display("FAIL rr_last got=%b/%0d/%h exp=1/3/a0000002", we, wreg, wdat);
        end
        rf_if.req_valid = '0;
        tick();
    endtask

    task automatic test_reg0();
        // Pointer is 0 here; grant requester 0 once so it moves to 1.
        rf_if.req_valid = 3'b001;
        @(negedge clock);
        checks++; if (rf_if.req_ready !== 3'b001) begin errors++; $display("FAIL r0_pre_ready got=%b exp=001", rf_if.req_ready); end
        tick();
        rf_if.req_valid = 3'b100;
        set_req(2, 5'd0, 32'h0000_1234);
        @(negedge clock);
        checks++; if (rf_if.req_ready !== 3'b100) begin errors++; $display("FAIL r0_ready got=%b exp=100", rf_if.req_ready); end
        tick();
        rf_if.req_valid = 3'b111;
        @(negedge clock);
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL r0_we got=%b exp=0", we); end
        checks++; if (wreg !== 5'd1 || wdat !== 32'hA000_0000) begin errors++; $display("FAIL r0_hold_out got=%0d/%h exp=1/a0000000", wreg, wdat); end
        checks++; if (rf_if.req_ready !== 3'b001) begin errors++; $display("FAIL r0_next_grant got=%b exp=001", rf_if.req_ready); end
        tick();
        rf_if.req_valid = '0;
        tick();
    endtask

    task automatic test_hold();
        // Pointer is 1 on entry.
        rf_if.wb_hold   = 1'b1;
        rf_if.req_valid = 3'b111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checks++; if (rf_if.req_ready !== 3'b000) begin errors++; $display("FAIL hold_ready[%0d] got=%b exp=000", c, rf_if.req_ready); end
            checks++; if (we !== 1'b0) begin errors++; $display("FAIL hold_we[%0d] got=%b exp=0", c, we); end
            tick();
        end
        rf_if.wb_hold = 1'b0;
        @(negedge clock);
        checks++; if (rf_if.req_ready !== 3'b010) begin errors++; $display("FAIL hold_release got=%b exp=010", rf_if.req_ready); end
        rf_if.req_valid = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        // Pointer is still 1: requester 1 is granted when alone.
        rf_if.req_valid = 3'b010;
        @(negedge clock);
        checks++; if (rf_if.req_ready !== 3'b010) begin errors++; $display("FAIL mid_pre_ready got=%b exp=010", rf_if.req_ready); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (rf_if.req_ready !== 3'b000) begin errors++; $display("FAIL mid_ready got=%b exp=000", rf_if.req_ready); end
        checks++; if (we !== 1'b0 || wreg !== 5'd0 || wdat !== 32'd0) begin
            errors++; $display("FAIL mid_outputs got=%b/%0d/%h exp=0/0/0", we, wreg, wdat);
        end
        rf_if.req_valid = 3'b111;
        tick();
        @(negedge clock);
        checks++; if (rf_if.req_ready !== 3'b000) begin errors++; $display("FAIL mid_in_reset_ready got=%b exp=000", rf_if.req_ready); end
        rst_n = 1'b1;
        #1;
        checks++; if (rf_if.req_ready !== 3'b001) begin errors++; $display("FAIL mid_after_ready got=%b exp=001", rf_if.req_ready); end
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL mid_after_we got=%b exp=0", we); end
        tick();
        @(negedge clock);
        checks++; if (we !== 1'b1 || wreg !== 5'd1) begin errors++; $display("FAIL mid_first_write got=%b/%0d exp=1/1", we, wreg); end
        rf_if.req_valid = '0;
        tick();
    endtask

    task automatic test_bypass();
        logic              exp_hit;
        logic [DATA_W-1:0] exp_dat;
`ifdef REGWB_BYPASS_EN
        exp_hit = 1'b1;
        exp_dat = 32'hCAFE_0001;
`else
        exp_hit = 1'b0;
        exp_dat = 32'd0;
`endif
        rf_if.req_valid = 3'b001;
        set_req(0, 5'd5, 32'hCAFE_0001);
        tick();
        rf_if.req_valid = '0;
        rd_a = 5'd5;
        rd_b = 5'd0;
        @(negedge clock);
        checks++; if (hit_a !== exp_hit) begin errors++; $display("FAIL byp_hitA got=%b exp=%b", hit_a, exp_hit); end
        checks++; if (bdat_a !== exp_dat) begin errors++; $display("FAIL byp_dataA got=%h exp=%h", bdat_a, exp_dat); end
        checks++; if (hit_b !== 1'b0 || bdat_b !== 32'd0) begin errors++; $display("FAIL byp_B_r0 got=%b/%h exp=0/0", hit_b, bdat_b); end
        rd_a = 5'd6;
        rd_b = 5'd5;
        #1;
        checks++; if (hit_a !== 1'b0) begin errors++; $display("FAIL byp_hitA_miss got=%b exp=0", hit_a); end
        checks++; if (hit_b !== exp_hit || bdat_b !== exp_dat) begin errors++; $display("FAIL byp_B_hit got=%b/%h exp=%b/%h", hit_b, bdat_b, exp_hit, exp_dat); end
        tick();
        rd_a = 5'd5;
        @(negedge clock);
        checks++; if (hit_a !== 1'b0 || bdat_a !== 32'd0) begin errors++; $display("FAIL byp_after_write got=%b/%h exp=0/0", hit_a, bdat_a); end
        rd_a = '0;
        rd_b = '0;
        tick();
    endtask

    initial begin
        rf_if.wb_hold   = 1'b0;
        rf_if.req_valid = '0;
        rf_if.req_reg   = '0;
        rf_if.req_data  = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_reg0();
        test_hold();
        test_reset_mid();
        test_bypass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
